// File: rtl/uart_cmd_parser.sv
// ASCII hex command-line decoder fed by async_receiver bytes.
// Decodes "W AA DDDD CR" writes and "R AA CR" reads into one-cycle strobes.
module uart_cmd_parser #(
    parameter int TIMEOUT_CYCLES = 43400,
    parameter bit ACCEPT_LOWER   = 1'b1
) (
    input  logic        CLK_10MHZ,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        wr_stb,
    output logic        rd_stb,
    output logic [7:0]  cmd_addr,
    output logic [15:0] cmd_data,
    output logic        cmd_err,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_DATA    = 3'd2,
        S_WAIT_CR = 3'd3,
        S_DISCARD = 3'd4
    } state_t;

    // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES-1.
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 2);

    // Returns {valid, nibble} for an ASCII hex digit.
    function automatic logic [4:0] hex_decode(input logic [7:0] ch, input logic lower_ok);
        logic [4:0] res;
        res = 5'b0_0000;
        if (ch >= 8'h30 && ch <= 8'h39) begin
            res = {1'b1, 4'(ch - 8'h30)};
        end else if (ch >= 8'h41 && ch <= 8'h46) begin
            res = {1'b1, 4'(ch - 8'h37)};
        end else if (lower_ok && ch >= 8'h61 && ch <= 8'h66) begin
            res = {1'b1, 4'(ch - 8'h57)};
        end else begin
            res = 5'b0_0000;
        end
        return res;
    endfunction

    state_t      state_r, state_s;
    logic [7:0]  addr_sh_r;
    logic [15:0] data_sh_r;
    logic [2:0]  nib_r;
    logic        is_wr_r;
    logic [15:0] to_cnt_r;

    logic [4:0]  hex_s;
    logic        hex_ok_s, is_cr_s, is_w_s, is_r_s, is_blank_s, timeout_s;
    logic        commit_s, err_s, addr_shift_s, data_shift_s, nib_clr_s;

    assign hex_s      = hex_decode(rx_data, ACCEPT_LOWER);
    assign hex_ok_s   = hex_s[4];
    assign is_cr_s    = (rx_data == 8'h0D);
    assign is_w_s     = (rx_data == 8'h57) || (ACCEPT_LOWER && rx_data == 8'h77);
    assign is_r_s     = (rx_data == 8'h52) || (ACCEPT_LOWER && rx_data == 8'h72);
    assign is_blank_s = is_cr_s || (rx_data == 8'h0A) || (rx_data == 8'h20);
    assign timeout_s  = !rx_valid && (state_r != S_IDLE) && (to_cnt_r == TO_LAST);

    // State register
    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; bytes only advance the FSM on rx_valid cycles
    always_comb begin
        state_s = state_r;
        if (timeout_s) begin
            state_s = S_IDLE;
        end else if (rx_valid) begin
            case (state_r)
                S_IDLE: begin
                    if (is_w_s || is_r_s)  state_s = S_ADDR;
                    else if (is_blank_s)   state_s = S_IDLE;
                    else                   state_s = S_DISCARD;
                end
                S_ADDR: begin
                    if (hex_ok_s)          state_s = (nib_r == 3'd1) ? (is_wr_r ? S_DATA : S_WAIT_CR) : S_ADDR;
                    else if (is_cr_s)      state_s = S_IDLE;
                    else                   state_s = S_DISCARD;
                end
                S_DATA: begin
                    if (hex_ok_s)          state_s = (nib_r == 3'd3) ? S_WAIT_CR : S_DATA;
                    else if (is_cr_s)      state_s = S_IDLE;
                    else                   state_s = S_DISCARD;
                end
                S_WAIT_CR: begin
                    if (is_cr_s)           state_s = S_IDLE;
                    else                   state_s = S_DISCARD;
                end
                S_DISCARD: begin
                    if (is_cr_s)           state_s = S_IDLE;
                    else                   state_s = S_DISCARD;
                end
                default:                   state_s = S_IDLE;
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // Action decode: shifts, nibble clears, commit and error events
    always_comb begin
        commit_s     = 1'b0;
        err_s        = 1'b0;
        addr_shift_s = 1'b0;
        data_shift_s = 1'b0;
        nib_clr_s    = 1'b0;
        if (timeout_s) begin
            err_s     = 1'b1;
            nib_clr_s = 1'b1;
        end else if (rx_valid) begin
            case (state_r)
                S_IDLE:    nib_clr_s = is_w_s || is_r_s;
                S_ADDR: begin
                    if (hex_ok_s) begin
                        addr_shift_s = 1'b1;
                        nib_clr_s    = (nib_r == 3'd1);
                    end else begin
                        err_s = is_cr_s;
                    end
                end
                S_DATA: begin
                    if (hex_ok_s) begin
                        data_shift_s = 1'b1;
                    end else begin
                        err_s = is_cr_s;
                    end
                end
                S_WAIT_CR: commit_s = is_cr_s;
                S_DISCARD: err_s    = is_cr_s;
                default:   err_s    = 1'b0;
            endcase
        end else begin
            err_s = 1'b0;
        end
    end

    // Shift registers, nibble counter, command type and idle timeout counter
    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            addr_sh_r <= 8'h00;
            data_sh_r <= 16'h0000;
            nib_r     <= 3'd0;
            is_wr_r   <= 1'b0;
            to_cnt_r  <= 16'h0000;
        end else begin
            if (addr_shift_s) addr_sh_r <= {addr_sh_r[3:0], hex_s[3:0]};
            if (data_shift_s) data_sh_r <= {data_sh_r[11:0], hex_s[3:0]};
            if (nib_clr_s) begin
                nib_r <= 3'd0;
            end else if (addr_shift_s || data_shift_s) begin
                nib_r <= nib_r + 3'd1;
            end
            if (rx_valid && state_r == S_IDLE && (is_w_s || is_r_s)) is_wr_r <= is_w_s;
            if (rx_valid || state_r == S_IDLE) begin
                to_cnt_r <= 16'h0000;
            end else if (to_cnt_r != 16'hFFFF) begin
                to_cnt_r <= to_cnt_r + 16'd1;
            end
        end
    end

    // Registered outputs; only a commit updates the address/data holding registers
    always_ff @(posedge CLK_10MHZ) begin
        if (rst) begin
            wr_stb   <= 1'b0;
            rd_stb   <= 1'b0;
            cmd_err  <= 1'b0;
            busy     <= 1'b0;
            cmd_addr <= 8'h00;
            cmd_data <= 16'h0000;
        end else begin
            wr_stb  <= commit_s && is_wr_r;
            rd_stb  <= commit_s && !is_wr_r;
            cmd_err <= err_s;
            busy    <= (state_s != S_IDLE);
            if (commit_s) cmd_addr <= addr_sh_r;
            if (commit_s && is_wr_r) cmd_data <= data_sh_r;
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser: unit A (defaults, lowercase on),
// unit B (TIMEOUT_CYCLES=100, uppercase only) driven from one byte source.
module tb_uart_cmd_parser;

    logic clk = 1'b0;
    always #50 clk = ~clk;

    logic rst, rx_valid, sel;
    logic [7:0] rx_data;
    logic rxv_a, rxv_b;
    logic wr_a, rd_a, err_a, busy_a, wr_b, rd_b, err_b, busy_b;
    logic [7:0] addr_a, addr_b;
    logic [15:0] data_a, data_b;

    assign rxv_a = rx_valid & ~sel;
    assign rxv_b = rx_valid & sel;

    uart_cmd_parser #(.TIMEOUT_CYCLES(43400), .ACCEPT_LOWER(1'b1)) dut_a (
        .CLK_10MHZ(clk), .rst(rst), .rx_valid(rxv_a), .rx_data(rx_data),
        .wr_stb(wr_a), .rd_stb(rd_a), .cmd_addr(addr_a), .cmd_data(data_a),
        .cmd_err(err_a), .busy(busy_a));

    uart_cmd_parser #(.TIMEOUT_CYCLES(100), .ACCEPT_LOWER(1'b0)) dut_b (
        .CLK_10MHZ(clk), .rst(rst), .rx_valid(rxv_b), .rx_data(rx_data),
        .wr_stb(wr_b), .rd_stb(rd_b), .cmd_addr(addr_b), .cmd_data(data_b),
        .cmd_err(err_b), .busy(busy_b));

    logic wr_s, rd_s, err_s, busy_s;
    logic [7:0] addr_s;
    logic [15:0] data_s;
    assign wr_s   = sel ? wr_b   : wr_a;
    assign rd_s   = sel ? rd_b   : rd_a;
    assign err_s  = sel ? err_b  : err_a;
    assign busy_s = sel ? busy_b : busy_a;
    assign addr_s = sel ? addr_b : addr_a;
    assign data_s = sel ? data_b : data_a;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int wr_cnt[2] = '{0, 0};
    int rd_cnt[2] = '{0, 0};
    int err_cnt[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe pulse counters, sampled mid-cycle
    always @(negedge clk) begin
        if (wr_a)  wr_cnt[0]  <= wr_cnt[0] + 1;
        if (rd_a)  rd_cnt[0]  <= rd_cnt[0] + 1;
        if (err_a) err_cnt[0] <= err_cnt[0] + 1;
        if (wr_b)  wr_cnt[1]  <= wr_cnt[1] + 1;
        if (rd_b)  rd_cnt[1]  <= rd_cnt[1] + 1;
        if (err_b) err_cnt[1] <= err_cnt[1] + 1;
    end

    typedef struct {
        bit        s;
        bit [79:0] msg;
        int        len;
        int        gap;
        bit        ew, er, ee;
        bit [7:0]  ea;
        bit [15:0] ed;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
        end
    endtask

    task automatic send_str(input bit [79:0] msg, input int len, input int gap);
        for (int i = 0; i < len; i++) begin
            send_byte(msg[8*(len-1-i) +: 8]);
            if (i < len - 1) idle(gap);
        end
    endtask

    task automatic run_frame(input string name, input bit s, input bit [79:0] msg, input int len,
                             input int gap, input bit ew, input bit er, input bit ee,
                             input bit [7:0] ea, input bit [15:0] ed);
        int w0, r0, e0;
        sel = s;
        w0 = wr_cnt[s]; r0 = rd_cnt[s]; e0 = err_cnt[s];
        send_str(msg, len, gap);
        chk({name, "_wr"},   32'(wr_s),   32'(ew));
        chk({name, "_rd"},   32'(rd_s),   32'(er));
        chk({name, "_err"},  32'(err_s),  32'(ee));
        chk({name, "_addr"}, 32'(addr_s), 32'(ea));
        chk({name, "_data"}, 32'(data_s), 32'(ed));
        idle(4);
        chk({name, "_nwr"},  32'(wr_cnt[s] - w0),  32'(ew));
        chk({name, "_nrd"},  32'(rd_cnt[s] - r0),  32'(er));
        chk({name, "_nerr"}, 32'(err_cnt[s] - e0), 32'(ee));
        chk({name, "_busy"}, 32'(busy_s), 32'd0);
    endtask

    initial begin
        int w0, r0, e0, t2, t_err;
        bit found;

        tbl[0]  = '{1'b0, 80'("W1A00FF\r"),   8, 433, 1'b1, 1'b0, 1'b0, 8'h1A, 16'h00FF};
        tbl[1]  = '{1'b0, 80'("R3c\r"),       4, 0,   1'b0, 1'b1, 1'b0, 8'h3C, 16'h00FF};
        tbl[2]  = '{1'b1, 80'("R3c\r"),       4, 0,   1'b0, 1'b0, 1'b1, 8'h00, 16'h0000};
        tbl[3]  = '{1'b0, 80'("W1G00\r"),     6, 0,   1'b0, 1'b0, 1'b1, 8'h3C, 16'h00FF};
        tbl[4]  = '{1'b0, 80'("R05\r"),       4, 0,   1'b0, 1'b1, 1'b0, 8'h05, 16'h00FF};
        tbl[5]  = '{1'b0, 80'("W12\r"),       4, 0,   1'b0, 1'b0, 1'b1, 8'h05, 16'h00FF};
        tbl[6]  = '{1'b0, 80'("W1234567\r"),  9, 0,   1'b0, 1'b0, 1'b1, 8'h05, 16'h00FF};
        tbl[7]  = '{1'b0, 80'("w12abCD\r"),   8, 0,   1'b1, 1'b0, 1'b0, 8'h12, 16'hABCD};
        tbl[8]  = '{1'b0, 80'(" \n\rR00\r"),  7, 0,   1'b0, 1'b1, 1'b0, 8'h00, 16'hABCD};
        tbl[9]  = '{1'b0, 80'("X\r"),         2, 0,   1'b0, 1'b0, 1'b1, 8'h00, 16'hABCD};
        tbl[10] = '{1'b1, 80'("Wab\r"),       4, 0,   1'b0, 1'b0, 1'b1, 8'h00, 16'h0000};
        tbl[11] = '{1'b1, 80'("WFF0000\r"),   8, 0,   1'b1, 1'b0, 1'b0, 8'hFF, 16'h0000};
        tbl[12] = '{1'b1, 80'("R3c\r"),       4, 0,   1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000};
        tbl[13] = '{1'b0, 80'("R\n\r"),       3, 0,   1'b0, 1'b0, 1'b1, 8'h00, 16'hABCD};
        tbl[14] = '{1'b1, 80'("r7e\r"),       4, 0,   1'b0, 1'b0, 1'b1, 8'hFF, 16'h0000};

        rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; sel = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a", {wr_a, rd_a, err_a, busy_a, addr_a, data_a}, 32'd0);
        chk("rst_b", {wr_b, rd_b, err_b, busy_b, addr_b, data_b}, 32'd0);
        rst = 1'b0;
        idle(2);

        for (int i = 0; i < 15; i++) begin
            run_frame($sformatf("v%0d", i), tbl[i].s, tbl[i].msg, tbl[i].len, tbl[i].gap,
                      tbl[i].ew, tbl[i].er, tbl[i].ee, tbl[i].ea, tbl[i].ed);
        end

        // Rejected frame followed back-to-back by a read, no idle cycle between
        sel = 1'b0;
        w0 = wr_cnt[0]; r0 = rd_cnt[0]; e0 = err_cnt[0];
        send_str(80'("W1G00\r"), 6, 0);
        chk("b2b_err", 32'(err_a), 32'd1);
        send_str(80'("R05\r"), 4, 0);
        chk("b2b_rd",   32'(rd_a),   32'd1);
        chk("b2b_addr", 32'(addr_a), 32'h05);
        idle(4);
        chk("b2b_nwr",  32'(wr_cnt[0] - w0),  32'd0);
        chk("b2b_nrd",  32'(rd_cnt[0] - r0),  32'd1);
        chk("b2b_nerr", 32'(err_cnt[0] - e0), 32'd1);

        // Stalled frame on unit B: error exactly 100 cycles after the last byte
        sel = 1'b1;
        e0 = err_cnt[1]; w0 = wr_cnt[1];
        send_str(80'("W12"), 3, 0);
        t2 = cyc - 1;
        found = 1'b0; t_err = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            if (cyc == t2 + 50) chk("to_busy_mid", 32'(busy_b), 32'd1);
            if (err_b && !found) begin
                found = 1'b1;
                t_err = cyc;
            end
        end
        chk("to_found", 32'(found), 32'd1);
        chk("to_delay", 32'(t_err - t2), 32'd100);
        chk("to_nerr",  32'(err_cnt[1] - e0), 32'd1);
        chk("to_nwr",   32'(wr_cnt[1] - w0), 32'd0);
        chk("to_busy",  32'(busy_b), 32'd0);
        run_frame("to_next", 1'b1, 80'("R7F\r"), 4, 0, 1'b0, 1'b1, 1'b0, 8'h7F, 16'h0000);

        // Reset mid-frame abandons it silently
        sel = 1'b0;
        e0 = err_cnt[0];
        send_str(80'("W12"), 3, 0);
        @(negedge clk);
        rx_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_out", {wr_a, rd_a, err_a, busy_a, addr_a, data_a}, 32'd0);
        idle(6);
        chk("mrst_nerr", 32'(err_cnt[0] - e0), 32'd0);
        run_frame("mrst_next", 1'b0, 80'("W55ABCD\r"), 8, 0, 1'b1, 1'b0, 1'b0, 8'h55, 16'hABCD);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
